// File: rtl/sqrt_controller.sv
// Control FSM for an iterative integer square root on a shared register-file datapath.
// Subtracts successive odd numbers from the operand and counts how many fit before it goes negative.
module sqrt_controller #(
  parameter logic [2:0] REG_REM = 3'd0,
  parameter logic [2:0] REG_ODD = 3'd1,
  parameter logic [2:0] REG_CNT = 3'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        flg_negative,
  output logic [13:0] ctrl_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_PASS = 2'b10;
  localparam logic [1:0] OP_INC  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CHKNEG = 4'd1,
    S_ZERO   = 4'd2,
    S_INIT1  = 4'd3,
    S_SUB    = 4'd4,
    S_INCC   = 4'd5,
    S_ODD1   = 4'd6,
    S_ODD2   = 4'd7,
    S_OUT    = 4'd8,
    S_DONE   = 4'd9,
    S_ERR    = 4'd10
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [13:0] ctrl_r;
  logic        busy_r;
  logic        done_r;
  logic        err_r;
  logic [13:0] load_word;

  // Control word layout: {sel, we, wr[2:0], ra[2:0], rb[2:0], op[1:0], oe}
  function automatic logic [13:0] pack_ctrl(
    input logic       sel,
    input logic       we,
    input logic [2:0] wr,
    input logic [2:0] ra,
    input logic [2:0] rb,
    input logic [1:0] op,
    input logic       oe
  );
    return {sel, we, wr, ra, rb, op, oe};
  endfunction

  function automatic logic [13:0] state_word(input state_t s);
    logic [13:0] w;
    w = '0;
    case (s)
      S_CHKNEG: w = pack_ctrl(1'b0, 1'b0, 3'd0,    REG_REM, 3'd0,    OP_PASS, 1'b0);
      S_ZERO:   w = pack_ctrl(1'b0, 1'b1, REG_CNT, REG_REM, REG_REM, OP_SUB,  1'b0);
      S_INIT1:  w = pack_ctrl(1'b0, 1'b1, REG_ODD, REG_CNT, 3'd0,    OP_INC,  1'b0);
      S_SUB:    w = pack_ctrl(1'b0, 1'b1, REG_REM, REG_REM, REG_ODD, OP_SUB,  1'b0);
      S_INCC:   w = pack_ctrl(1'b0, 1'b1, REG_CNT, REG_CNT, 3'd0,    OP_INC,  1'b0);
      S_ODD1,
      S_ODD2:   w = pack_ctrl(1'b0, 1'b1, REG_ODD, REG_ODD, 3'd0,    OP_INC,  1'b0);
      S_OUT:    w = pack_ctrl(1'b0, 1'b0, 3'd0,    REG_CNT, 3'd0,    OP_PASS, 1'b1);
      default:  w = '0;
    endcase
    return w;
  endfunction

  assign load_word = pack_ctrl(1'b1, 1'b1, REG_REM, 3'd0, 3'd0, OP_ADD, 1'b0);

  // flg_negative only matters at the end of CHKNEG and SUB
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:   state_nxt = start_i ? S_CHKNEG : S_IDLE;
      S_CHKNEG: state_nxt = flg_negative ? S_ERR : S_ZERO;
      S_ZERO:   state_nxt = S_INIT1;
      S_INIT1:  state_nxt = S_SUB;
      S_SUB:    state_nxt = flg_negative ? S_OUT : S_INCC;
      S_INCC:   state_nxt = S_ODD1;
      S_ODD1:   state_nxt = S_ODD2;
      S_ODD2:   state_nxt = S_SUB;
      S_OUT:    state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      S_ERR:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      ctrl_r <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      state  <= state_nxt;
      ctrl_r <= state_word(state_nxt);
      busy_r <= (state_nxt != S_IDLE);
      done_r <= (state_nxt == S_DONE);
      err_r  <= (state_nxt == S_ERR);
    end
  end

  // The operand load is the one word that must follow start_i within the same cycle
  assign ctrl_o = (state == S_IDLE && start_i) ? load_word : ctrl_r;
  assign busy_o = busy_r;
  assign done_o = done_r;
  assign err_o  = err_r;

endmodule

// File: tb/tb_sqrt_controller.sv
// Bench for sqrt_controller: drives a behavioural register-file datapath from ctrl_o and
// checks results, latencies, pulses and reset behaviour against plain-arithmetic expectations.
module tb_sqrt_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        flg_negative;
  logic [13:0] ctrl_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] data_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sqrt_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .flg_negative (flg_negative),
    .ctrl_o       (ctrl_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  // Datapath: 8x32 register file, two read ports, small ALU, output register
  logic [31:0] rf [8] = '{default: 32'd0};
  logic [31:0] data_o = 32'd0;
  logic [31:0] alu_a, alu_b, alu_y;

  always_comb begin
    alu_a = rf[ctrl_o[8:6]];
    alu_b = rf[ctrl_o[5:3]];
    case (ctrl_o[2:1])
      2'b00:   alu_y = alu_a + alu_b;
      2'b01:   alu_y = alu_a - alu_b;
      2'b10:   alu_y = alu_a;
      default: alu_y = alu_a + 32'd1;
    endcase
  end
  assign flg_negative = alu_y[31];

  always @(posedge clk) begin
    if (ctrl_o[12]) rf[ctrl_o[11:9]] <= ctrl_o[13] ? data_i : alu_y;
    if (ctrl_o[0])  data_o <= alu_y;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Per-cycle invariants: writes only to the three working registers, OE only right before done
  bit oe_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      oe_prev = 1'b0;
    end else begin
      if (ctrl_o[12] && !ctrl_o[13])
        check("we_addr", {63'd0, (ctrl_o[11:9] inside {3'd0, 3'd1, 3'd2})}, 64'd1);
      if (oe_prev) check("oe_then_done", {63'd0, done_o}, 64'd1);
      oe_prev = ctrl_o[0];
    end
  end

  // Reference: floor(sqrt(x)) by plain search; negative operands are errors
  function automatic logic [31:0] ref_sqrt(input logic [31:0] x);
    longint r;
    r = 0;
    while ((r + 1) * (r + 1) <= longint'(x)) r++;
    return r[31:0];
  endfunction

  // Issue one start and wait for done_o/err_o; cycle counted from the start cycle
  task automatic run_op(input logic [31:0] x, output int cyc, output bit got_done, output bit got_err);
    got_done = 1'b0;
    got_err  = 1'b0;
    cyc      = -1;
    @(posedge clk); #1;
    start_i = 1'b1;
    data_i  = x;
    @(posedge clk); #1;
    start_i = 1'b0;
    data_i  = $urandom;
    check("busy_cycle1", {63'd0, busy_o}, 64'd1);
    for (int n = 1; n < 20000; n++) begin
      if (done_o || err_o) begin
        got_done = done_o;
        got_err  = err_o;
        cyc      = n;
        break;
      end
      @(posedge clk); #1;
    end
    if (cyc < 0) begin
      errors++;
      $display("FAIL timeout: no done/err for x=0x%0h", x);
    end
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] root;
    bit          err;
    int          lat;
  } vec_t;

  vec_t        vecs [15];
  logic [31:0] last_root;

  task automatic apply(input vec_t v);
    int cyc;
    bit gd, ge;
    run_op(v.x, cyc, gd, ge);
    check("latency", 64'(cyc), 64'(v.lat));
    check("done_flag", {63'd0, gd}, {63'd0, !v.err});
    check("err_flag", {63'd0, ge}, {63'd0, v.err});
    if (v.err) check("data_o_kept", {32'd0, data_o}, {32'd0, last_root});
    else begin
      check("data_o", {32'd0, data_o}, {32'd0, v.root});
      last_root = v.root;
    end
    @(posedge clk); #1;
    check("pulse_end", {62'd0, done_o, err_o}, 64'd0);
    check("busy_idle", {63'd0, busy_o}, 64'd0);
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{32'd0,          32'd0,   1'b0, 6};
    vecs[1]  = '{32'd1,          32'd1,   1'b0, 10};
    vecs[2]  = '{32'd2,          32'd1,   1'b0, 10};
    vecs[3]  = '{32'd3,          32'd1,   1'b0, 10};
    vecs[4]  = '{32'd4,          32'd2,   1'b0, 14};
    vecs[5]  = '{32'd16,         32'd4,   1'b0, 22};
    vecs[6]  = '{32'd17,         32'd4,   1'b0, 22};
    vecs[7]  = '{32'd24,         32'd4,   1'b0, 22};
    vecs[8]  = '{32'd25,         32'd5,   1'b0, 26};
    vecs[9]  = '{32'h8000_0000,  32'd0,   1'b1, 2};
    vecs[10] = '{32'd99,         32'd9,   1'b0, 42};
    vecs[11] = '{32'd100,        32'd10,  1'b0, 46};
    vecs[12] = '{32'hFFFF_FFFF,  32'd0,   1'b1, 2};
    vecs[13] = '{32'd65535,      32'd255, 1'b0, 1026};
    vecs[14] = '{32'd65536,      32'd256, 1'b0, 1030};
    last_root = 32'd0;

    // Reset: idle outputs, and the load word still tracks start_i
    rst_n   = 1'b0;
    start_i = 1'b0;
    data_i  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", {50'd0, ctrl_o}, 64'd0);
    check("rst_flags", {61'd0, busy_o, done_o, err_o}, 64'd0);
    start_i = 1'b1;
    #1;
    check("rst_load_word", {50'd0, ctrl_o}, 64'h3000);
    start_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) apply(vecs[i]);

    // Randomized operands against the arithmetic reference
    for (int i = 0; i < 12; i++) begin
      v.x = ($urandom_range(0, 3) == 0) ? (32'h8000_0000 | $urandom) : 32'($urandom_range(0, 20000));
      v.err  = v.x[31];
      v.root = v.err ? 32'd0 : ref_sqrt(v.x);
      v.lat  = v.err ? 2 : 6 + 4 * int'(v.root);
      apply(v);
    end
    v = '{32'd1_000_000, 32'd1000, 1'b0, 4006};
    apply(v);

    // Restart while busy is ignored, then reset aborts without a pulse
    @(posedge clk); #1;
    start_i = 1'b1;
    data_i  = 32'd100;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      start_i = (n == 3);
      data_i  = (n == 3) ? 32'd5 : 32'd0;
      if (n == 3) check("busy_restart_ignored", {63'd0, ctrl_o[13]}, 64'd0);
      if (n < 10) check("no_pulse_before_rst", {62'd0, done_o, err_o}, 64'd0);
    end
    start_i = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy_o}, 64'd0);
    check("midrst_ctrl", {50'd0, ctrl_o}, 64'd0);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      check("midrst_no_pulse", {61'd0, busy_o, done_o, err_o}, 64'd0);
    end
    rst_n = 1'b1;
    v = '{32'd9, 32'd3, 1'b0, 18};
    apply(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
